// File: rtl/x01_pkg.sv
// x01_pkg: shared constants, undo record layout and throw legality check for the x01 scorekeeper
package x01_pkg;
  localparam int BULL = 25;
  localparam int DARTS_PER_TURN = 3;
  localparam int MAX_PTS = 60;
  // Record fields are sized for the largest supported configuration (8 players, 16-bit scores);
  // the controller zero-extends on push and truncates on pop.
  localparam int REC_PLAYER_W = 3;
  localparam int REC_SCORE_W = 16;
  typedef struct packed {
    logic [REC_PLAYER_W-1:0] player;
    logic [1:0]              dart;
    logic [REC_SCORE_W-1:0]  prev_score;
    logic [REC_SCORE_W-1:0]  turn_start;
    logic                    was_over;
  } undo_rec_t;
  function automatic logic legal_throw(input logic [4:0] points, input logic [1:0] multiplier);
    return (points <= 5'd20 || points == 5'(BULL)) && multiplier != 2'd0 &&
           !(points == 5'(BULL) && multiplier == 2'd3);
  endfunction
endpackage

// File: rtl/x01_undo_stack.sv
// x01_undo_stack: LIFO history that overwrites its oldest entry when full
//   clk, reset   : clock and asynchronous active-high reset
//   clr          : synchronous flush
//   push, wdata  : store a new newest entry
//   pop          : discard the newest entry (ignored when empty)
//   rdata        : newest entry
//   empty, count : occupancy, count saturates at DEPTH
module x01_undo_stack #(
  parameter int DEPTH = 8,
  parameter int W = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 wdata,
  output logic [W-1:0]                 rdata,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] ptr_q, ptr_prev, ptr_next;
  logic [CW-1:0] cnt_q;
  logic          do_pop, do_push;
  // ptr_q is the slot the next push writes; the newest entry sits one slot behind it
  assign ptr_prev = (ptr_q == '0) ? AW'(DEPTH - 1) : ptr_q - AW'(1);
  assign ptr_next = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign rdata    = mem_q[ptr_prev];
  assign do_pop   = !clr && pop && !empty;
  assign do_push  = !clr && !do_pop && push;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (do_pop) begin
      ptr_q <= ptr_prev;
      cnt_q <= cnt_q - CW'(1);
    end else if (do_push) begin
      ptr_q <= ptr_next;
      cnt_q <= (cnt_q == CW'(DEPTH)) ? cnt_q : cnt_q + CW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[ptr_q] <= wdata;
  end
endmodule

// File: rtl/x01_multi_player_controller.sv
// x01_multi_player_controller: multi-player x01 darts scorekeeper with bust, double-out and undo
//   clk, reset          : clock and asynchronous active-high reset
//   new_game            : synchronous restart
//   throw_valid         : a dart landed, scored by points (0 miss, 1..20, 25 bull) x multiplier (1..3)
//   undo                : revert the newest accepted dart (wins over a same-cycle throw)
//   scores              : packed remaining scores, player 0 in the LSBs
//   cur_player, dart_idx: active player and dart within the turn
//   bust, err           : one-cycle pulses for an applied bust / a rejected throw or undo
//   game_over, winner   : level after a legal checkout and the player who made it
module x01_multi_player_controller
  import x01_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int START_SCORE = 501,
  parameter int SCORE_W = 10,
  parameter int UNDO_DEPTH = 8,
  parameter int DOUBLE_OUT = 1,
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          new_game,
  input  logic                          throw_valid,
  input  logic [4:0]                    points,
  input  logic [1:0]                    multiplier,
  input  logic                          undo,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic [PW-1:0]                 cur_player,
  output logic [1:0]                    dart_idx,
  output logic                          bust,
  output logic                          game_over,
  output logic [PW-1:0]                 winner,
  output logic                          err
);
  localparam logic [SCORE_W-1:0] START = SCORE_W'(START_SCORE);
  logic [SCORE_W-1:0] sc_q [NUM_PLAYERS];
  logic [SCORE_W-1:0] sc_d [NUM_PLAYERS];
  logic [PW-1:0]      cur_q, cur_d, win_q, win_d, nxt, ridx;
  logic [1:0]         dart_q, dart_d;
  logic [SCORE_W-1:0] ts_q, ts_d, cur_sc;
  logic               over_q, over_d, bust_q, bust_d, err_q, err_d;
  logic [6:0]         pts;
  logic [SCORE_W:0]   diff;
  logic               is_bust, turn_end, push, pop, clr, h_empty, hist_empty;
  logic [$clog2(UNDO_DEPTH+1)-1:0] h_cnt;
  undo_rec_t          wrec, rrec;
  x01_undo_stack #(.DEPTH(UNDO_DEPTH), .W($bits(undo_rec_t))) u_hist (
    .clk(clk), .reset(reset), .clr(clr), .push(push), .pop(pop),
    .wdata(wrec), .rdata(rrec), .empty(h_empty), .count(h_cnt)
  );
  assign hist_empty = h_empty || h_cnt == '0;
  assign cur_sc = sc_q[cur_q];
  assign pts    = 7'(points) * 7'(multiplier);
  // One extra MSB so that pts > score shows up as a set sign bit
  assign diff   = {1'b0, cur_sc} - (SCORE_W+1)'(pts);
  assign is_bust = diff[SCORE_W] ||
                   (DOUBLE_OUT != 0 && (diff == (SCORE_W+1)'(1) || (diff == '0 && multiplier != 2'd2)));
  assign nxt  = (cur_q == PW'(NUM_PLAYERS - 1)) ? '0 : cur_q + PW'(1);
  assign ridx = PW'(rrec.player);
  always_comb begin
    wrec            = '0;
    wrec.player     = REC_PLAYER_W'(cur_q);
    wrec.dart       = dart_q;
    wrec.prev_score = REC_SCORE_W'(cur_sc);
    wrec.turn_start = REC_SCORE_W'(ts_q);
    wrec.was_over   = over_q;
  end
  always_comb begin
    sc_d     = sc_q;
    cur_d    = cur_q;
    dart_d   = dart_q;
    ts_d     = ts_q;
    over_d   = over_q;
    win_d    = win_q;
    bust_d   = 1'b0;
    err_d    = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    clr      = 1'b0;
    turn_end = 1'b0;
    if (new_game) begin
      for (int i = 0; i < NUM_PLAYERS; i++) sc_d[i] = START;
      cur_d  = '0;
      dart_d = '0;
      ts_d   = START;
      over_d = 1'b0;
      win_d  = '0;
      clr    = 1'b1;
    end else if (undo) begin
      if (hist_empty) begin
        err_d = 1'b1;
      end else begin
        pop        = 1'b1;
        cur_d      = ridx;
        dart_d     = rrec.dart;
        sc_d[ridx] = SCORE_W'(rrec.prev_score);
        ts_d       = SCORE_W'(rrec.turn_start);
        over_d     = rrec.was_over;
      end
    end else if (throw_valid) begin
      if (!legal_throw(points, multiplier) || over_q) begin
        err_d = 1'b1;
      end else begin
        push = 1'b1;
        if (is_bust) begin
          sc_d[cur_q] = ts_q;
          bust_d      = 1'b1;
          turn_end    = 1'b1;
        end else if (diff == '0) begin
          sc_d[cur_q] = '0;
          over_d      = 1'b1;
          win_d       = cur_q;
        end else begin
          sc_d[cur_q] = diff[SCORE_W-1:0];
          dart_d      = dart_q + 2'd1;
          turn_end    = (dart_q == 2'(DARTS_PER_TURN - 1));
        end
      end
    end
    // The incoming player's turn starts from whatever score it holds after this cycle's update
    if (turn_end) begin
      cur_d  = nxt;
      dart_d = '0;
      ts_d   = sc_d[nxt];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PLAYERS; i++) sc_q[i] <= START;
      cur_q  <= '0;
      dart_q <= '0;
      ts_q   <= START;
      over_q <= 1'b0;
      win_q  <= '0;
      bust_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      sc_q   <= sc_d;
      cur_q  <= cur_d;
      dart_q <= dart_d;
      ts_q   <= ts_d;
      over_q <= over_d;
      win_q  <= win_d;
      bust_q <= bust_d;
      err_q  <= err_d;
    end
  end
  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_sc
    assign scores[g*SCORE_W +: SCORE_W] = sc_q[g];
  end
  assign cur_player = cur_q;
  assign dart_idx   = dart_q;
  assign bust       = bust_q;
  assign game_over  = over_q;
  assign winner     = win_q;
  assign err        = err_q;
endmodule

// File: tb/tb_x01_multi_player_controller.sv
// tb_x01_multi_player_controller: two configurations driven in lockstep against a rule-level model
module tb_x01_multi_player_controller;
  logic clk = 1'b0, reset = 1'b1, new_game = 1'b0, throw_valid = 1'b0, undo = 1'b0;
  logic [4:0] points = '0;
  logic [1:0] multiplier = '0;
  logic [19:0] a_sc;
  logic [29:0] b_sc;
  logic [0:0] a_cur, a_win;
  logic [1:0] b_cur, b_win, a_dart, b_dart;
  logic a_bust, b_bust, a_over, b_over, a_err, b_err;
  x01_multi_player_controller #(.NUM_PLAYERS(2), .START_SCORE(501), .SCORE_W(10), .UNDO_DEPTH(4), .DOUBLE_OUT(1)) dut_a (
    .clk(clk), .reset(reset), .new_game(new_game), .throw_valid(throw_valid), .points(points),
    .multiplier(multiplier), .undo(undo), .scores(a_sc), .cur_player(a_cur), .dart_idx(a_dart),
    .bust(a_bust), .game_over(a_over), .winner(a_win), .err(a_err));
  x01_multi_player_controller #(.NUM_PLAYERS(3), .START_SCORE(41), .SCORE_W(10), .UNDO_DEPTH(8), .DOUBLE_OUT(1)) dut_b (
    .clk(clk), .reset(reset), .new_game(new_game), .throw_valid(throw_valid), .points(points),
    .multiplier(multiplier), .undo(undo), .scores(b_sc), .cur_player(b_cur), .dart_idx(b_dart),
    .bust(b_bust), .game_over(b_over), .winner(b_win), .err(b_err));
  always #5 clk = ~clk;
  typedef struct { int cur; int dart; int prev; int ts; int over; } rec_t;
  int np [2] = '{2, 3};
  int st [2] = '{501, 41};
  int dep [2] = '{4, 8};
  int sc [2][8];
  int cur [2], dart [2], ts [2], over [2], win [2], bst [2], er [2];
  rec_t hist [2][$];
  int n_vec = 0, n_mis = 0;
  task automatic init(input int k);
    for (int i = 0; i < 8; i++) sc[k][i] = st[k];
    cur[k] = 0; dart[k] = 0; ts[k] = st[k]; over[k] = 0; win[k] = 0; bst[k] = 0; er[k] = 0;
    hist[k].delete();
  endtask
  task automatic end_turn(input int k);
    cur[k] = (cur[k] + 1) % np[k];
    dart[k] = 0;
    ts[k] = sc[k][cur[k]];
  endtask
  task automatic model(input int k, input bit ng, input bit u, input bit tv, input int p, input int m);
    rec_t r;
    int n;
    bst[k] = 0; er[k] = 0;
    if (ng) init(k);
    else if (u) begin
      if (hist[k].size() == 0) er[k] = 1;
      else begin
        r = hist[k].pop_back();
        cur[k] = r.cur; dart[k] = r.dart; sc[k][r.cur] = r.prev; ts[k] = r.ts; over[k] = r.over;
      end
    end else if (tv) begin
      if (!((p <= 20 || p == 25) && m != 0 && !(p == 25 && m == 3)) || over[k] != 0) er[k] = 1;
      else begin
        r = '{cur[k], dart[k], sc[k][cur[k]], ts[k], over[k]};
        if (hist[k].size() == dep[k]) void'(hist[k].pop_front());
        hist[k].push_back(r);
        n = sc[k][cur[k]] - p * m;
        if (n < 0 || n == 1 || (n == 0 && m != 2)) begin
          sc[k][cur[k]] = ts[k]; bst[k] = 1; end_turn(k);
        end else if (n == 0) begin
          sc[k][cur[k]] = 0; over[k] = 1; win[k] = cur[k];
        end else begin
          sc[k][cur[k]] = n;
          if (dart[k] == 2) end_turn(k); else dart[k]++;
        end
      end
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic check_all();
    logic [31:0] e;
    for (int k = 0; k < 2; k++) begin
      e = '0;
      for (int i = 0; i < np[k]; i++) e = e | (32'(sc[k][i]) << (10 * i));
      chk($sformatf("k%0d scores", k), k == 0 ? 32'(a_sc) : 32'(b_sc), e);
      chk($sformatf("k%0d cur_player", k), k == 0 ? 32'(a_cur) : 32'(b_cur), 32'(cur[k]));
      chk($sformatf("k%0d dart_idx", k), k == 0 ? 32'(a_dart) : 32'(b_dart), 32'(dart[k]));
      chk($sformatf("k%0d bust", k), k == 0 ? 32'(a_bust) : 32'(b_bust), 32'(bst[k]));
      chk($sformatf("k%0d err", k), k == 0 ? 32'(a_err) : 32'(b_err), 32'(er[k]));
      chk($sformatf("k%0d game_over", k), k == 0 ? 32'(a_over) : 32'(b_over), 32'(over[k]));
      chk($sformatf("k%0d winner", k), k == 0 ? 32'(a_win) : 32'(b_win), 32'(win[k]));
    end
  endtask
  task automatic step(input bit ng, input bit u, input bit tv, input int p, input int m);
    new_game = ng; undo = u; throw_valid = tv; points = 5'(p); multiplier = 2'(m);
    @(posedge clk);
    for (int k = 0; k < 2; k++) model(k, ng, u, tv, p, m);
    @(negedge clk);
    new_game = 1'b0; undo = 1'b0; throw_valid = 1'b0;
    check_all();
  endtask
  task automatic throw(input int p, input int m);
    step(1'b0, 1'b0, 1'b1, p, m);
  endtask
  task automatic do_undo();
    step(1'b0, 1'b1, 1'b0, 0, 0);
  endtask
  task automatic restart();
    step(1'b1, 1'b0, 1'b0, 0, 0);
  endtask
  initial begin
    int r, p, m;
    repeat (2) @(negedge clk);
    init(0); init(1);
    check_all();
    reset = 1'b0;
    throw(20, 3); throw(20, 3); throw(20, 3);
    restart();
    throw(20, 3); throw(5, 1); do_undo(); do_undo(); do_undo();
    throw(22, 1); throw(25, 3); throw(5, 0); throw(31, 2);
    restart();
    throw(20, 3); throw(20, 1); throw(1, 1); throw(19, 3); throw(19, 1); throw(1, 1);
    repeat (5) do_undo();
    throw(10, 1);
    step(1'b0, 1'b1, 1'b1, 20, 3);
    restart();
    throw(1, 1); throw(20, 2); throw(5, 1); do_undo();
    restart();
    throw(20, 1); throw(20, 1); throw(25, 2);
    for (int n = 0; n < 700; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        #1;
        init(0); init(1);
        check_all();
        @(negedge clk);
        reset = 1'b0;
      end
      r = $urandom_range(0, 99);
      p = $urandom_range(0, 21);
      if (p == 21) p = 25;
      if ($urandom_range(0, 9) == 0) p = $urandom_range(0, 31);
      m = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 3);
      if (r < 2) restart();
      else if (r < 14) do_undo();
      else if (r < 17) step(1'b0, 1'b1, 1'b1, p, m);
      else if (r < 20) step(1'b0, 1'b0, 1'b0, p, m);
      else throw(p, m);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
